// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter.
//   Accepts a WIDTH-bit word over a valid/ready handshake and emits it one
//   bit per clock on a registered serial line. Consecutive words can be sent
//   with no gap: the next word is accepted on the edge that ends the last bit.
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   data_in    - parallel word, captured only on an accept edge
//   valid_in   - upstream has a word on data_in
//   ready_out  - block can accept this cycle (combinational from state)
//   data_out   - serial bit (registered)
//   frame_out  - high while data_out carries a payload bit (registered)
//   last_out   - high during the final bit of a word (registered)
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             frame_out,
    output logic             last_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             data_out_q, data_out_d;
    logic             frame_q, frame_d;
    logic             last_q, last_d;
    logic             accept;
    logic [WIDTH-1:0] sh_next;

    // The head bit always sits at the end the word leaves from, so shifting
    // moves the next transmit bit into the head position.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[WIDTH-1];
    endfunction

    assign sh_next = LSB_FIRST ? {1'b0, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};

    // Ready in IDLE, or on the last-bit cycle so the next word follows gap-free.
    assign ready_out = !rst && ((state_q == IDLE) || (cnt_q == CNT_LAST));
    assign accept    = valid_in && ready_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sh_d    = data_in;
                end
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                    sh_d  = sh_next;
                end else if (accept) begin
                    cnt_d = '0;
                    sh_d  = data_in;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sh_d    = '0;
            end
        endcase

        // Outputs are registered from next-state so bit 0 appears right at the
        // accept edge.
        frame_d    = (state_d == SHIFT);
        data_out_d = frame_d ? head_bit(sh_d) : 1'b0;
        last_d     = frame_d && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            data_out_q <= 1'b0;
            frame_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            data_out_q <= data_out_d;
            frame_q    <= frame_d;
            last_q     <= last_d;
        end
    end

    assign data_out  = data_out_q;
    assign frame_out = frame_q;
    assign last_out  = last_q;

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out, data_out, frame_out, last_out;
    logic       m_ready_out, m_data_out, m_frame_out, m_last_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .data_out(data_out),
        .frame_out(frame_out), .last_out(last_out)
    );

    piso_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(m_ready_out), .data_out(m_data_out),
        .frame_out(m_frame_out), .last_out(m_last_out)
    );

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle(input string name);
        checks++;
        if ({data_out, frame_out, last_out} !== 3'b000) begin
            failures++;
            $display("FAIL %s idle: got d/f/l=%b%b%b want 000", name, data_out, frame_out, last_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b1; data_in = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({data_out, frame_out, last_out, ready_out} !== 4'b0000) begin
                failures++;
                $display("FAIL reset cyc%0d: got d/f/l/r=%b%b%b%b want 0000",
                         i, data_out, frame_out, last_out, ready_out);
            end
        end
        rst = 1'b0; valid_in = 1'b0;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin
            failures++;
            $display("FAIL reset ready_after: got %b want 1", ready_out);
        end
        tick();
        test_idle("reset_after");
    endtask

    task automatic test_single_lsb();
        bit exp_seq[8] = '{0, 0, 1, 0, 1, 1, 0, 1};
        valid_in = 1'b1; data_in = 8'hB4;
        tick();
        valid_in = 1'b0; data_in = 8'h00;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({data_out, frame_out, last_out, ready_out} !==
                {exp_seq[k], 1'b1, k == 7, k == 7}) begin
                failures++;
                $display("FAIL single_lsb bit%0d: got d/f/l/r=%b%b%b%b want %b1%b%b",
                         k, data_out, frame_out, last_out, ready_out,
                         exp_seq[k], k == 7, k == 7);
            end
            tick();
        end
        test_idle("single_lsb");
    endtask

    task automatic test_msb_first();
        bit exp_seq[8] = '{1, 0, 1, 1, 0, 1, 0, 0};
        valid_in = 1'b1; data_in = 8'hB4;
        tick();
        valid_in = 1'b0; data_in = 8'h00;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({m_data_out, m_frame_out, m_last_out} !== {exp_seq[k], 1'b1, k == 7}) begin
                failures++;
                $display("FAIL msb_first bit%0d: got d/f/l=%b%b%b want %b1%b",
                         k, m_data_out, m_frame_out, m_last_out, exp_seq[k], k == 7);
            end
            tick();
        end
        checks++;
        if ({m_data_out, m_frame_out, m_last_out} !== 3'b000) begin
            failures++;
            $display("FAIL msb_first idle: got d/f/l=%b%b%b want 000",
                     m_data_out, m_frame_out, m_last_out);
        end
    endtask

    task automatic test_back_to_back();
        valid_in = 1'b1; data_in = 8'hFF;
        tick();
        data_in = 8'h00;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) valid_in = 1'b0;
            checks++;
            if ({data_out, frame_out, last_out, ready_out} !==
                {k < 8, 1'b1, (k == 7) || (k == 15), (k == 7) || (k == 15)}) begin
                failures++;
                $display("FAIL back_to_back cyc%0d: got d/f/l/r=%b%b%b%b want %b1%b%b",
                         k, data_out, frame_out, last_out, ready_out,
                         k < 8, (k == 7) || (k == 15), (k == 7) || (k == 15));
            end
            tick();
        end
        test_idle("back_to_back");
    endtask

    task automatic test_stall();
        bit seq_a[8] = '{0, 0, 1, 1, 1, 1, 0, 0};  // 8'h3C
        bit seq_b[8] = '{0, 1, 0, 1, 1, 0, 1, 0};  // 8'h5A
        valid_in = 1'b1; data_in = 8'h3C;
        tick();
        for (int k = 0; k < 8; k++) begin
            // Junk words offered while busy; only the k==7 word may be taken.
            data_in = (k == 7) ? 8'h5A : 8'(8'h11 * (k + 1));
            #1;
            checks++;
            if ({data_out, frame_out, ready_out} !== {seq_a[k], 1'b1, k == 7}) begin
                failures++;
                $display("FAIL stall_a bit%0d: got d/f/r=%b%b%b want %b1%b",
                         k, data_out, frame_out, ready_out, seq_a[k], k == 7);
            end
            tick();
        end
        valid_in = 1'b0; data_in = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({data_out, frame_out, last_out} !== {seq_b[k], 1'b1, k == 7}) begin
                failures++;
                $display("FAIL stall_b bit%0d: got d/f/l=%b%b%b want %b1%b",
                         k, data_out, frame_out, last_out, seq_b[k], k == 7);
            end
            tick();
        end
        test_idle("stall");
    endtask

    task automatic test_reset_mid_word();
        bit seq_a[3] = '{1, 1, 0};                  // 8'hC3 first bits
        bit seq_b[8] = '{0, 1, 1, 0, 1, 0, 0, 1};  // 8'h96
        valid_in = 1'b1; data_in = 8'hC3;
        tick();
        valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({data_out, frame_out} !== {seq_a[k], 1'b1}) begin
                failures++;
                $display("FAIL midrst_pre bit%0d: got d/f=%b%b want %b1",
                         k, data_out, frame_out, seq_a[k]);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({data_out, frame_out, last_out, ready_out} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_edge: got d/f/l/r=%b%b%b%b want 0000",
                     data_out, frame_out, last_out, ready_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            test_idle("midrst_quiet");
        end
        valid_in = 1'b1; data_in = 8'h96;
        tick();
        valid_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({data_out, frame_out, last_out} !== {seq_b[k], 1'b1, k == 7}) begin
                failures++;
                $display("FAIL midrst_next bit%0d: got d/f/l=%b%b%b want %b1%b",
                         k, data_out, frame_out, last_out, seq_b[k], k == 7);
            end
            tick();
        end
        test_idle("midrst_next");
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0;
        #1;
        test_reset();
        test_single_lsb();
        tick();
        test_msb_first();
        tick();
        test_back_to_back();
        tick();
        test_stall();
        tick();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
